ex_add128_seq: RTL and testbench

- Sequenced add/subtract front-end for the 64-bit carry-select adder in EX.
- Latches operands, forms the B operand and carry-in, and handles 64-bit ops in one pass.
- Splits 128-bit ops into low and high 64-bit passes, handing the carry between them.
- Delivers a registered result with carry and overflow to the EX writeback mux.

---
 rtl/ex_add128_seq.sv | 165 ++++++++++++++++
 tb/tb_ex_add128_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_add128_seq.sv
// Sequenced 64/128-bit add/subtract front-end for the EX carry-select adder.
// Optional signed saturating ADDS64/SUBS64 (opcodes 110/111) under `JX2_EXADD_SAT_EN.
module ex_add128_seq (
    input  logic         clock,
    input  logic         reset,
    input  logic         hold,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   opcode,
    input  logic [127:0] valA,
    input  logic [127:0] valB,
    input  logic         carry_in,
    output logic         out_valid,
    output logic [127:0] out_val,
    output logic         out_carry,
    output logic         out_ovf,
    output logic         busy
);

    typedef enum logic {S_IDLE, S_HI} state_t;

    state_t        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [127:0]  out_val_q, out_val_d;
    logic          out_carry_q, out_carry_d;
    logic          out_ovf_q, out_ovf_d;
    logic [63:0]   lo_q, lo_d;
    logic          cy_q, cy_d;
    logic [63:0]   ahi_q, ahi_d;
    logic [63:0]   bhi_q, bhi_d;
    logic          sub_hi_q, sub_hi_d;

    logic          accept;
    logic          is_128;
    logic [63:0]   a_op, b_op;
    logic          c_op;
    logic [64:0]   sum;
    logic          ovf;

    assign in_ready = (state_q == S_IDLE) && !hold;
    assign accept   = in_valid && in_ready;
    assign is_128   = (opcode[2:1] == 2'b10);

    // Reset wins over hold; hold freezes the FSM.
    // NOTE: sequential state uses non-blocking assignments only; comb blocks use blocking.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (!hold) begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_128) state_d = S_HI;
            S_HI:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand formation: the high pass reuses the same 64-bit adder.
    always_comb begin
        a_op = valA[63:0];
        b_op = opcode[0] ? ~valB[63:0] : valB[63:0];
        case (opcode)
            3'b001, 3'b101, 3'b111: c_op = 1'b1;
            3'b010, 3'b011:         c_op = carry_in;
            default:                c_op = 1'b0;
        endcase
        if (state_q == S_HI) begin
            a_op = ahi_q;
            b_op = sub_hi_q ? ~bhi_q : bhi_q;
            c_op = cy_q;
        end
    end

    assign sum = {1'b0, a_op} + {1'b0, b_op} + {64'd0, c_op};
    assign ovf = (a_op[63] == b_op[63]) && (sum[63] != a_op[63]);

    always_comb begin
        out_valid_d = 1'b0;
        out_val_d   = out_val_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        lo_d        = lo_q;
        cy_d        = cy_q;
        ahi_d       = ahi_q;
        bhi_d       = bhi_q;
        sub_hi_d    = sub_hi_q;
        if (state_q == S_HI) begin
            out_valid_d = 1'b1;
            out_val_d   = {sum[63:0], lo_q};
            out_carry_d = sum[64];
            out_ovf_d   = ovf;
        end else if (accept) begin
            case (opcode)
                3'b100, 3'b101: begin
                    lo_d     = sum[63:0];
                    cy_d     = sum[64];
                    ahi_d    = valA[127:64];
                    bhi_d    = valB[127:64];
                    sub_hi_d = opcode[0];
                end
                3'b110, 3'b111: begin
                    out_valid_d = 1'b1;
`ifdef JX2_EXADD_SAT_EN
                    // Clamp toward the sign of A: overflow always flips the result sign.
                    if (ovf) begin
                        out_val_d = {64'd0, a_op[63] ? 64'h8000_0000_0000_0000
                                                     : 64'h7FFF_FFFF_FFFF_FFFF};
                    end else begin
                        out_val_d = {64'd0, sum[63:0]};
                    end
                    out_carry_d = sum[64];
                    out_ovf_d   = ovf;
`else
                    out_val_d   = 128'd0;
                    out_carry_d = 1'b0;
                    out_ovf_d   = 1'b0;
`endif
                end
                default: begin
                    out_valid_d = 1'b1;
                    out_val_d   = {64'd0, sum[63:0]};
                    out_carry_d = sum[64];
                    out_ovf_d   = ovf;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_val_q   <= 128'd0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            lo_q        <= 64'd0;
            cy_q        <= 1'b0;
            ahi_q       <= 64'd0;
            bhi_q       <= 64'd0;
            sub_hi_q    <= 1'b0;
        end else if (!hold) begin
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            lo_q        <= lo_d;
            cy_q        <= cy_d;
            ahi_q       <= ahi_d;
            bhi_q       <= bhi_d;
            sub_hi_q    <= sub_hi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q == S_HI);

endmodule

// File: tb/tb_ex_add128_seq.sv
// Self-checking bench for ex_add128_seq: directed scenarios plus randomized traffic
// checked against an arithmetic reference model. Honours `JX2_EXADD_SAT_EN.
module tb_ex_add128_seq;

    logic         clock = 1'b0;
    logic         reset;
    logic         hold;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [127:0] valA;
    logic [127:0] valB;
    logic         carry_in;
    logic         out_valid;
    logic [127:0] out_val;
    logic         out_carry;
    logic         out_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] val;
        logic         carry;
        logic         ovf;
    } res_t;

    ex_add128_seq dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .valA      (valA),
        .valB      (valB),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_val   (out_val),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Reference: exact integer arithmetic on unsigned and signed views of the operands.
    function automatic res_t model(input logic [2:0] op, input logic [127:0] a,
                                   input logic [127:0] b, input logic cin);
        res_t r;
        int w;
        logic [130:0] ua, ub, ut, lim, kk, bw;
        logic signed [130:0] sa, sb, st, smax, smin;
        logic k;
        r = '0;
        w = (op == 3'b100 || op == 3'b101) ? 128 : 64;
        if (w == 64) begin
            ua = {67'd0, a[63:0]};
            ub = {67'd0, b[63:0]};
            sa = {{67{a[63]}}, a[63:0]};
            sb = {{67{b[63]}}, b[63:0]};
        end else begin
            ua = {3'd0, a};
            ub = {3'd0, b};
            sa = {{3{a[127]}}, a};
            sb = {{3{b[127]}}, b};
        end
        k  = (op == 3'b010 || op == 3'b011) ? cin : op[0];
        kk = {130'd0, k};
        bw = {130'd0, ~k};
        lim = 131'd1 << w;
        if (!op[0]) begin
            ut = ua + ub + kk;
            r.carry = (ut >= lim);
            st = sa + sb + $signed(kk);
        end else begin
            ut = ua - ub - bw;
            r.carry = (ua >= ub + bw);
            st = sa - sb - $signed(bw);
        end
        r.val = 128'(ut & (lim - 131'd1));
        smax = $signed(lim >> 1) - 131'sd1;
        smin = -$signed(lim >> 1);
        r.ovf = (st > smax) || (st < smin);
        if (op[2:1] == 2'b11) begin
`ifdef JX2_EXADD_SAT_EN
            if (r.ovf) r.val = (st < 0) ? {64'd0, 64'h8000_0000_0000_0000}
                                        : {64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
`else
            r = '0;
`endif
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
            2:       return 128'($urandom_range(0, 3));
            3:       return {$urandom, 32'h8000_0000, $urandom, 32'h0};
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [127:0] a,
                         input logic [127:0] b, input logic c);
        in_valid = 1'b1;
        opcode   = op;
        valA     = a;
        valB     = b;
        carry_in = c;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; in_valid = 1'b0;
        opcode = 3'd0; valA = '0; valB = '0; carry_in = 1'b0;
        cycle(); cycle();
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b val=%h c=%b o=%b busy=%b, expected all zero",
                     out_valid, out_val, out_carry, out_ovf, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add64();
        drive(3'b000, 128'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf} !== {1'b1, 128'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add64_wrap: got v=%b val=%h c=%b o=%b, expected v=1 val=0 c=1 o=0",
                     out_valid, out_val, out_carry, out_ovf);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL add64_pulse: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sub64();
        drive(3'b001, 128'h8000_0000_0000_0000, 128'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf} !==
            {1'b1, 128'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub64_ovf: got v=%b val=%h c=%b o=%b, expected v=1 val=7fff..ffff c=1 o=1",
                     out_valid, out_val, out_carry, out_ovf);
        end
        cycle();
    endtask

    task automatic test_add128();
        drive(3'b100, 128'h1_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL add128_hi_state: got busy/ready/valid=%b%b%b expected 100",
                     busy, in_ready, out_valid);
        end
        cycle();
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf} !==
            {1'b1, 128'h2_0000_0000_0000_0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add128_result: got v=%b val=%h c=%b o=%b, expected v=1 val=2_0000..0 c=0 o=0",
                     out_valid, out_val, out_carry, out_ovf);
        end
        cycle();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL add128_done: got valid/busy=%b%b expected 00", out_valid, busy);
        end
    endtask

    task automatic test_hold();
        int pulses;
        drive(3'b101, 128'd0, 128'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({out_valid, busy, in_ready} !== 3'b010) begin
                errors++;
                $display("FAIL hold_hi_frozen: cycle %0d got valid/busy/ready=%b%b%b expected 010",
                         i, out_valid, busy, in_ready);
            end
        end
        hold = 1'b0;
        cycle();
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf} !== {1'b1, {128{1'b1}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub128_result: got v=%b val=%h c=%b o=%b, expected v=1 val=all-ones c=0 o=0",
                     out_valid, out_val, out_carry, out_ovf);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL sub128_single_pulse: extra pulses got %0d expected 0", pulses);
        end
        // A completed 64-bit result must stay visible while held.
        drive(3'b000, 128'd3, 128'd4, 1'b0);
        cycle();
        in_valid = 1'b0;
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if ({out_valid, out_val} !== {1'b1, 128'd7}) begin
                errors++;
                $display("FAIL hold_pending_valid: got v=%b val=%h expected v=1 val=7", out_valid, out_val);
            end
        end
        hold = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release_drop: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(3'b100, 128'h1_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
        cycle();
        in_valid = 1'b0;
        reset = 1'b0;
        hold = 1'b1;
        cycle();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_abort: got valid/busy=%b%b expected 00", out_valid, busy);
        end
        reset = 1'b1;
        hold = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: got %b expected 1", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_result: out_valid got %b expected 0", out_valid);
        end
        drive(3'b010, 128'd5, 128'd6, 1'b1);
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf} !== {1'b1, 128'd12, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL adc64_after_reset: got v=%b val=%h c=%b o=%b, expected v=1 val=12 c=0 o=0",
                     out_valid, out_val, out_carry, out_ovf);
        end
        cycle();
    endtask

    task automatic test_reserved();
        res_t exp_r;
`ifdef JX2_EXADD_SAT_EN
        exp_r = '{val: {64'd0, 64'h7FFF_FFFF_FFFF_FFFF}, carry: 1'b0, ovf: 1'b1};
`else
        exp_r = '0;
`endif
        drive(3'b110, 128'h7FFF_FFFF_FFFF_FFF0, 128'h20, 1'b0);
        cycle();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_val, out_carry, out_ovf} !== {1'b1, exp_r}) begin
            errors++;
            $display("FAIL op110: got v=%b val=%h c=%b o=%b, expected v=1 val=%h c=%b o=%b",
                     out_valid, out_val, out_carry, out_ovf, exp_r.val, exp_r.carry, exp_r.ovf);
        end
        cycle();
    endtask

    task automatic test_random();
        logic exp_v;
        bit   pend;
        bit   acc;
        res_t m, hi_r, exp_r;
        exp_v = 1'b0; pend = 1'b0; exp_r = '0; hi_r = '0; m = '0;
        for (int i = 0; i < 400; i++) begin
            hold     = ($urandom_range(0, 6) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            opcode   = 3'($urandom_range(0, 7));
            valA     = rnd128();
            valB     = rnd128();
            carry_in = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (in_ready !== (!hold && !pend)) begin
                errors++;
                $display("FAIL rand_ready: iter %0d got %b expected %b", i, in_ready, !hold && !pend);
            end
            acc = in_valid && !hold && !pend;
            if (acc) m = model(opcode, valA, valB, carry_in);
            cycle();
            if (!hold) begin
                if (pend) begin
                    exp_v = 1'b1; exp_r = hi_r; pend = 1'b0;
                end else if (acc && opcode[2:1] == 2'b10) begin
                    exp_v = 1'b0; hi_r = m; pend = 1'b1;
                end else if (acc) begin
                    exp_v = 1'b1; exp_r = m;
                end else begin
                    exp_v = 1'b0;
                end
            end
            checks++;
            if ({out_valid, busy} !== {exp_v, pend}) begin
                errors++;
                $display("FAIL rand_valid_busy: iter %0d got %b%b expected %b%b",
                         i, out_valid, busy, exp_v, pend);
            end
            if (exp_v) begin
                checks++;
                if ({out_val, out_carry, out_ovf} !== exp_r) begin
                    errors++;
                    $display("FAIL rand_result: iter %0d got val=%h c=%b o=%b expected val=%h c=%b o=%b",
                             i, out_val, out_carry, out_ovf, exp_r.val, exp_r.carry, exp_r.ovf);
                end
            end
        end
        in_valid = 1'b0;
        hold = 1'b0;
        cycle(); cycle();
    endtask

    initial begin
        test_reset();
        test_add64();
        test_sub64();
        test_add128();
        test_hold();
        test_reset_mid();
        test_reserved();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
